// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Optional stream checksum is built when IMEM_LOADER_CSUM_EN is defined.
package imem_loader_pkg;

  localparam int unsigned LANES              = 4;
  localparam int unsigned IMEM_BYTES_DEFAULT = 80;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_LOADER_CSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  typedef struct packed {
    logic in_ready;
    logic cpu_hold;
    logic load_done;
    logic load_error;
  } flags_t;

  // Output levels tied to each state, loaded together with the state register.
  function automatic flags_t state_flags(input state_t s);
    flags_t f;
    f.in_ready   = (s == LEN_LO) || (s == LEN_HI) || (s == DATA)
`ifdef IMEM_LOADER_CSUM_EN
                   || (s == CSUM)
`endif
                   ;
    f.cpu_hold   = (s != DONE);
    f.load_done  = (s == DONE);
    f.load_error = (s == ERROR);
    return f;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four stream bytes into a little-endian word; flags the word on lane 3.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] lanes_lo;
  logic [1:0]  lane;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes_lo <= '0;
      lane     <= '0;
    end else if (clear) begin
      lanes_lo <= '0;
      lane     <= '0;
    end else if (take) begin
      if (lane != 2'(LANES - 1))
        lanes_lo[8*lane +: 8] <= in_byte;
      lane <= lane + 2'd1;
    end
  end

  // Lane 3 is forwarded straight from the stream so the word is ready on acceptance.
  assign word      = {in_byte, lanes_lo};
  assign word_done = take && (lane == 2'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: length header, word writes, optional checksum.
// Checksum byte and CSUM state exist only when IMEM_LOADER_CSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = IMEM_BYTES_DEFAULT,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [31:0] AVAIL = 32'(MEM_BYTES - BASE_ADDR);
  localparam logic [31:0] BASE  = 32'(BASE_ADDR);

  state_t      state;
  flags_t      flags;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] word_index;
  logic [31:0] asm_word;
  logic        asm_done;
  logic        accept;
  logic        restart;
  logic [15:0] hdr_len;
  logic [31:0] hdr_bytes;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  csum;
`endif

  assign accept    = in_valid && flags.in_ready;
  assign restart   = start && ((state == DONE) || (state == ERROR));
  assign hdr_len   = {in_byte, len_lo};
  assign hdr_bytes = {14'b0, hdr_len, 2'b00};

  assign in_ready   = flags.in_ready;
  assign cpu_hold   = flags.cpu_hold;
  assign load_done  = flags.load_done;
  assign load_error = flags.load_error;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart),
    .take      (accept && (state == DATA)),
    .in_byte   (in_byte),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      flags      <= state_flags(IDLE);
      len_lo     <= '0;
      len        <= '0;
      word_index <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          state <= LEN_LO;
          flags <= state_flags(LEN_LO);
        end
        LEN_LO: if (accept) begin
          len_lo <= in_byte;
          state  <= LEN_HI;
          flags  <= state_flags(LEN_HI);
        end
        LEN_HI: if (accept) begin
          len <= hdr_len;
          if (hdr_bytes > AVAIL) begin
            state <= ERROR;
            flags <= state_flags(ERROR);
          end else if (hdr_len == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state <= CSUM;
            flags <= state_flags(CSUM);
`else
            state <= DONE;
            flags <= state_flags(DONE);
`endif
          end else begin
            state <= DATA;
            flags <= state_flags(DATA);
          end
        end
        DATA: if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
          csum <= csum ^ in_byte;
`endif
          if (asm_done) begin
            wr_en      <= 1'b1;
            wr_addr    <= BASE + {14'b0, word_index, 2'b00};
            wr_data    <= asm_word;
            word_index <= word_index + 16'd1;
            if (word_index == len - 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
              state <= CSUM;
              flags <= state_flags(CSUM);
`else
              state <= DONE;
              flags <= state_flags(DONE);
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        CSUM: if (accept) begin
          state <= (csum == in_byte) ? DONE : ERROR;
          flags <= state_flags((csum == in_byte) ? DONE : ERROR);
        end
`endif
        DONE, ERROR: if (start) begin
          state      <= LEN_LO;
          flags      <= state_flags(LEN_LO);
          word_index <= '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum       <= '0;
`endif
        end
        default: begin
          state <= IDLE;
          flags <= state_flags(IDLE);
        end
      endcase
    end
  end

endmodule
